// File: rtl/mult9x9_pipe_pkg.sv
// Shared widths, operand payload and helpers for the registered 9x9 multiplier.
// Optional signed support is enabled by defining MULT9X9_PIPE_SIGNED_EN.
package mult9x9_pkg;

   localparam int unsigned OPA_W  = 9;
   localparam int unsigned OPB_W  = 9;
   localparam int unsigned PROD_W = 18;

   // Operand beat as carried through the operand slice.
   typedef struct packed {
      logic [OPA_W-1:0] a;
      logic [OPB_W-1:0] b;
      logic             sgn;
   } operand_t;

   localparam int unsigned OPERAND_W = $bits(operand_t);

   // Number of register slices, equal to the input-to-output latency in cycles.
   function automatic int unsigned stage_count(input bit reg_input, input bit reg_output);
      return 32'(1) + 32'(reg_input) + 32'(reg_output);
   endfunction

   // Full-width product; sign-extending to the product width makes the truncated
   // unsigned multiply equal to the two's complement product.
   function automatic logic [PROD_W-1:0] mul9x9(input operand_t op);
      logic [PROD_W-1:0] ext_a;
      logic [PROD_W-1:0] ext_b;
      ext_a = op.sgn ? {{(PROD_W-OPA_W){op.a[OPA_W-1]}}, op.a}
                     : {{(PROD_W-OPA_W){1'b0}}, op.a};
      ext_b = op.sgn ? {{(PROD_W-OPB_W){op.b[OPB_W-1]}}, op.b}
                     : {{(PROD_W-OPB_W){1'b0}}, op.b};
      return ext_a * ext_b;
   endfunction

endpackage

// File: rtl/mult9x9_pipe_if.sv
// Operand/result handshake bundle of mult9x9_pipe.
// SIGNED is present only when MULT9X9_PIPE_SIGNED_EN is defined.
interface mult9x9_pipe_if;
   import mult9x9_pkg::*;

   logic              IN_VALID;
   logic              IN_READY;
   logic [OPA_W-1:0]  A;
   logic [OPB_W-1:0]  B;
`ifdef MULT9X9_PIPE_SIGNED_EN
   logic              SIGNED;
`endif
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [PROD_W-1:0] Z;

   // Producer/consumer side
   modport master (
`ifdef MULT9X9_PIPE_SIGNED_EN
      output SIGNED,
`endif
      output IN_VALID, A, B, OUT_READY,
      input  IN_READY, OUT_VALID, Z
   );

   // Multiplier side
   modport slave (
`ifdef MULT9X9_PIPE_SIGNED_EN
      input  SIGNED,
`endif
      input  IN_VALID, A, B, OUT_READY,
      output IN_READY, OUT_VALID, Z
   );
endinterface

// File: rtl/mult9x9_pipe_slice.sv
// One valid/ready register slice; accepts when empty or when downstream drains.
module mult9x9_pipe_slice #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready_c,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   assign in_ready_c = !out_valid || out_ready;

   // Load on accept; data only moves with a valid beat so it holds otherwise
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready_c) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/mult9x9_pipe.sv
// Registered 9x9 multiplier: optional operand slice, product slice, optional result slice.
// Define MULT9X9_PIPE_SIGNED_EN to add the SIGNED operand qualifier.
module mult9x9_pipe
   import mult9x9_pkg::*;
#(
   parameter bit REGINPUT  = 1'b1,
   parameter bit REGOUTPUT = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   mult9x9_pipe_if.slave bus
);

   operand_t          op_in;
   logic              op_valid;
   operand_t          op_data;
   logic              s0_ready_c;
   logic              s1_ready_c;
   logic              s2_ready_c;
   logic [PROD_W-1:0] prod_c;
   logic              p_valid;
   logic [PROD_W-1:0] p_data;

   // Operand beat assembly
   assign op_in.a = bus.A;
   assign op_in.b = bus.B;
`ifdef MULT9X9_PIPE_SIGNED_EN
   assign op_in.sgn = bus.SIGNED;
`else
   assign op_in.sgn = 1'b0;
`endif

   assign bus.IN_READY = s0_ready_c;

   // S0 operand slice
   generate
      if (REGINPUT) begin : g_s0
         mult9x9_pipe_slice #(.WIDTH(OPERAND_W)) u_s0 (
            .CLK        (CLK),
            .RST        (RST),
            .in_valid   (bus.IN_VALID),
            .in_ready_c (s0_ready_c),
            .in_data    (op_in),
            .out_valid  (op_valid),
            .out_ready  (s1_ready_c),
            .out_data   (op_data)
         );
      end else begin : g_s0_byp
         assign op_valid   = bus.IN_VALID;
         assign op_data    = op_in;
         assign s0_ready_c = s1_ready_c;
      end
   endgenerate

   assign prod_c = mul9x9(op_data);

   // S1 product slice
   mult9x9_pipe_slice #(.WIDTH(PROD_W)) u_s1 (
      .CLK        (CLK),
      .RST        (RST),
      .in_valid   (op_valid),
      .in_ready_c (s1_ready_c),
      .in_data    (prod_c),
      .out_valid  (p_valid),
      .out_ready  (s2_ready_c),
      .out_data   (p_data)
   );

   // S2 result slice
   generate
      if (REGOUTPUT) begin : g_s2
         mult9x9_pipe_slice #(.WIDTH(PROD_W)) u_s2 (
            .CLK        (CLK),
            .RST        (RST),
            .in_valid   (p_valid),
            .in_ready_c (s2_ready_c),
            .in_data    (p_data),
            .out_valid  (bus.OUT_VALID),
            .out_ready  (bus.OUT_READY),
            .out_data   (bus.Z)
         );
      end else begin : g_s2_byp
         assign bus.OUT_VALID = p_valid;
         assign bus.Z         = p_data;
         assign s2_ready_c    = bus.OUT_READY;
      end
   endgenerate

endmodule

// File: tb/tb_mult9x9_pipe.sv
// Directed self-checking bench for mult9x9_pipe (default and fully bypassed builds).
module tb_mult9x9_pipe;
   import mult9x9_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   mult9x9_pipe_if bus0 ();
   mult9x9_pipe_if bus1 ();

   mult9x9_pipe #(.REGINPUT(1'b1), .REGOUTPUT(1'b1)) u_dut0 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus0)
   );

   mult9x9_pipe #(.REGINPUT(1'b0), .REGOUTPUT(1'b0)) u_dut1 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus1)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [PROD_W-1:0] sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single beat through the default pipe, result checked after the full latency
   task automatic run_one(input string tag, input logic [8:0] a, input logic [8:0] b,
                          input logic sgn, input logic [17:0] exp);
      bus0.OUT_READY = 1'b1;
      bus0.IN_VALID  = 1'b1;
      bus0.A         = a;
      bus0.B         = b;
`ifdef MULT9X9_PIPE_SIGNED_EN
      bus0.SIGNED    = sgn;
`else
      if (sgn) $display("note: signed vector skipped in unsigned build");
`endif
      for (int c = 1; c <= int'(stage_count(1'b1, 1'b1)); c++) begin
         tick();
         bus0.IN_VALID = 1'b0;
         check({tag, "_valid"}, 32'(bus0.OUT_VALID), 32'(c == 3));
      end
      check({tag, "_z"}, 32'(bus0.Z), 32'(exp));
      tick();
`ifdef MULT9X9_PIPE_SIGNED_EN
      bus0.SIGNED = 1'b0;
`endif
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int sent, got, stalls, first_out, last_out, acc, drained, seen;
      logic [8:0] a, b;
      logic [8:0] bp_a[4];
      logic [8:0] bp_b[4];
      logic [17:0] bp_exp[3];
      bp_a = '{9'd5, 9'd42, 9'd79, 9'd116};
      bp_b = '{9'd3, 9'd14, 9'd25, 9'd36};
      bp_exp = '{18'd15, 18'd588, 18'd1975};

      bus0.IN_VALID = 1'b0; bus0.A = '0; bus0.B = '0; bus0.OUT_READY = 1'b1;
      bus1.IN_VALID = 1'b0; bus1.A = '0; bus1.B = '0; bus1.OUT_READY = 1'b1;
`ifdef MULT9X9_PIPE_SIGNED_EN
      bus0.SIGNED = 1'b0;
      bus1.SIGNED = 1'b0;
`endif

      // Reset state
      tick(); tick();
      check("rst_out_valid", 32'(bus0.OUT_VALID), 0);
      check("rst_z", 32'(bus0.Z), 0);
      RST = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus0.IN_READY), 1);

      // Latency of the default pipe with the largest operands
      run_one("lat_max", 9'd511, 9'd511, 1'b0, 18'd261121);

      // Back-to-back streaming against the scoreboard
      sent = 0; got = 0; stalls = 0; first_out = -1; last_out = -1;
      bus0.OUT_READY = 1'b1;
      for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
         if (sent < 100) begin
            a = 9'($urandom_range(0, 511));
            b = 9'($urandom_range(0, 511));
            bus0.IN_VALID = 1'b1; bus0.A = a; bus0.B = b;
         end else begin
            bus0.IN_VALID = 1'b0;
         end
         #1;
         if (bus0.IN_VALID && bus0.IN_READY) begin
            sb.push_back(18'(32'(a) * 32'(b)));
            sent++;
         end else if (bus0.IN_VALID) begin
            stalls++;
         end
         if (bus0.OUT_VALID) begin
            if (sb.size() != 0) check("stream_z", 32'(bus0.Z), 32'(sb.pop_front()));
            else check("stream_spurious", 32'(bus0.OUT_VALID), 0);
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         tick();
      end
      bus0.IN_VALID = 1'b0;
      check("stream_count", 32'(got), 100);
      check("stream_in_stalls", 32'(stalls), 0);
      check("stream_out_span", 32'(last_out - first_out + 1), 100);

      // Backpressure: stalled consumer fills all three slices
      acc = 0;
      bus0.OUT_READY = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus0.IN_VALID = 1'b1;
         bus0.A = bp_a[acc];
         bus0.B = bp_b[acc];
         #1;
         if (bus0.IN_READY) acc++;
         tick();
      end
      check("bp_accepted", 32'(acc), 3);
      check("bp_in_ready", 32'(bus0.IN_READY), 0);
      check("bp_out_valid", 32'(bus0.OUT_VALID), 1);
      bus0.IN_VALID = 1'b0;
      bus0.OUT_READY = 1'b1;
      drained = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (bus0.OUT_VALID) begin
            if (drained < 3) check("bp_drain_z", 32'(bus0.Z), 32'(bp_exp[drained]));
            drained++;
         end
         tick();
      end
      check("bp_drained", 32'(drained), 3);
      check("bp_idle", 32'(bus0.OUT_VALID), 0);

      // Reset with two beats in flight
      bus0.IN_VALID = 1'b1; bus0.A = 9'd100; bus0.B = 9'd100;
      tick();
      bus0.A = 9'd200; bus0.B = 9'd200;
      tick();
      bus0.IN_VALID = 1'b0;
      RST = 1'b1;
      #1;
      check("midrst_out_valid", 32'(bus0.OUT_VALID), 0);
      check("midrst_z", 32'(bus0.Z), 0);
      tick(); tick();
      RST = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus0.OUT_VALID) seen++;
      end
      check("midrst_stale", 32'(seen), 0);
      check("midrst_in_ready", 32'(bus0.IN_READY), 1);

      // Fully bypassed build: single-cycle latency
      bus1.OUT_READY = 1'b1;
      bus1.IN_VALID = 1'b1; bus1.A = 9'd3; bus1.B = 9'd5;
      #1;
      check("byp_in_ready", 32'(bus1.IN_READY), 1);
      check("byp_pre_valid", 32'(bus1.OUT_VALID), 0);
      tick();
      bus1.IN_VALID = 1'b0;
      check("byp_valid", 32'(bus1.OUT_VALID), 1);
      check("byp_z", 32'(bus1.Z), 15);
      tick();
      check("byp_post_valid", 32'(bus1.OUT_VALID), 0);

`ifdef MULT9X9_PIPE_SIGNED_EN
      // Two's complement product versus unsigned interpretation
      run_one("sgn_neg", 9'h1FF, 9'd2, 1'b1, 18'h3FFFE);
      run_one("uns_same", 9'h1FF, 9'd2, 1'b0, 18'd1022);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
